// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, select codes and default prices
// for the snack vending controller.
package vending_pkg;
  typedef enum logic [2:0] {SELECT, DRINK, CHIP, INSERT, CHANGE} state_e;
  localparam logic [2:0] SEL_DRINK = 3'b001;
  localparam logic [2:0] SEL_CHIP = 3'b010;
  localparam int DEF_DRINK_PRICE = 3;
  localparam int DEF_CHIP_PRICE = 2;
endpackage

// File: rtl/btn_press_det.sv
// btn_press_det: one-shot press pulse from an active-low push-button.
// Ports: clk, rst (sync, active-high), btn_n (button, idle 1),
// press (high in the cycle btn_n falls; holding low gives no more pulses).
module btn_press_det (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  logic btn_d, btn_q;
  always_comb btn_d = btn_n;
  always_ff @(posedge clk) btn_q <= rst ? 1'b1 : btn_d;
  assign press = btn_q & ~btn_n;
endmodule

// File: rtl/vending_snack_fsm.sv
// vending_snack_fsm: single-item vending controller returning paid - price.
// Ports: clk, rst (sync, active-high), b0 confirm (active-low),
// b1 cancel (active-low, used only with VM_CANCEL_EN defined),
// select (001 drink, 010 chip), amnt (paid amount), change (registered).
// Macro VM_CANCEL_EN: enables cancel/refund on b1.
module vending_snack_fsm
  import vending_pkg::*;
#(
  parameter int W = 3,
  parameter int DRINK_PRICE = DEF_DRINK_PRICE,
  parameter int CHIP_PRICE = DEF_CHIP_PRICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         b0,
  input  logic         b1,
  input  logic [W-1:0] select,
  input  logic [W-1:0] amnt,
  output logic [W-1:0] change
);
  state_e state_d, state_q;
  logic [W-1:0] price_d, price_q, paid_d, paid_q, change_d, change_q;
  logic b0_p, b1_p;
  btn_press_det u_b0 (.clk(clk), .rst(rst), .btn_n(b0), .press(b0_p));
`ifdef VM_CANCEL_EN
  btn_press_det u_b1 (.clk(clk), .rst(rst), .btn_n(b1), .press(b1_p));
`else
  logic unused_b1;
  assign unused_b1 = b1;
  assign b1_p = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    price_d = price_q;
    paid_d = paid_q;
    change_d = change_q;
    // Cancel outranks a simultaneous confirm; in CHANGE it refunds the last sample.
    if (b1_p && state_q != SELECT) begin
      state_d = SELECT;
      change_d = state_q == CHANGE ? paid_q : '0;
    end else begin
      case (state_q)
        SELECT: begin
          if (select == W'(SEL_DRINK)) begin
            state_d = DRINK;
            price_d = W'(DRINK_PRICE);
            change_d = '0;
          end else if (select == W'(SEL_CHIP)) begin
            state_d = CHIP;
            price_d = W'(CHIP_PRICE);
            change_d = '0;
          end
        end
        DRINK, CHIP: state_d = b0_p ? INSERT : state_q;
        INSERT: begin
          if (b0_p) begin
            paid_d = amnt;
            state_d = CHANGE;
          end
        end
        CHANGE: begin
          if (b0_p) begin
            paid_d = amnt;
            change_d = amnt >= price_q ? amnt - price_q : '0;
            state_d = amnt >= price_q ? SELECT : CHANGE;
          end
        end
        default: state_d = SELECT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SELECT;
      price_q <= '0;
      paid_q <= '0;
      change_q <= '0;
    end else begin
      state_q <= state_d;
      price_q <= price_d;
      paid_q <= paid_d;
      change_q <= change_d;
    end
  end
  assign change = change_q;
endmodule

// File: tb/tb_vending_snack_fsm.sv
// tb_vending_snack_fsm: directed and random stimulus checked every cycle
// against a transaction-level model of the vending controller.
module tb_vending_snack_fsm;
  logic clk = 1'b0, rst = 1'b1, b0 = 1'b1, b1 = 1'b1;
  logic [2:0] select = '0, amnt = '0;
  logic [2:0] change;
  int checks = 0, errors = 0;
  vending_snack_fsm dut (.clk(clk), .rst(rst), .b0(b0), .b1(b1), .select(select), .amnt(amnt), .change(change));
  always #5 clk = ~clk;
`ifdef VM_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  // Model: confirms counts confirm presses since an item was chosen (-1 = no item).
  int confirms = -1, price = 0, paid = 0, exp_change = 0;
  bit prev0 = 1'b1, prev1 = 1'b1, started = 1'b0;
  always @(posedge clk) begin
    bit p0, p1;
    started = 1'b1;
    if (rst) begin
      confirms = -1; price = 0; paid = 0; exp_change = 0; prev0 = 1'b1; prev1 = 1'b1;
    end else begin
      p0 = prev0 && !b0;
      p1 = CANCEL && prev1 && !b1;
      prev0 = b0;
      prev1 = b1;
      if (p1 && confirms >= 0) begin
        exp_change = confirms == 2 ? paid : 0;
        confirms = -1;
      end else if (confirms < 0) begin
        if (select == 3'd1 || select == 3'd2) begin
          price = select == 3'd1 ? 3 : 2;
          confirms = 0;
          exp_change = 0;
        end
      end else if (p0) begin
        if (confirms < 2) begin
          if (confirms == 1) paid = amnt;
          confirms++;
        end else begin
          paid = amnt;
          exp_change = amnt >= price ? amnt - price : 0;
          if (amnt >= price) confirms = -1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (change !== 3'(exp_change)) begin
        errors++;
        $display("FAIL cycle_change t=%0t got %b want %b", $time, change, 3'(exp_change));
      end
    end
  end
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic press0();
    b0 = 1'b0; tick(); b0 = 1'b1; tick();
  endtask
  task automatic pick(input logic [2:0] s);
    select = s; tick(); select = '0; tick();
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    chk("reset_change", int'(change), 0);
    chk("reset_model_idle", confirms, -1);
    pick(3'b001); press0(); amnt = 3'b101; press0(); press0();
    chk("drink_over_change", int'(change), 2);
    chk("drink_over_idle", confirms, -1);
    pick(3'b010); press0(); amnt = 3'b001; press0(); press0();
    chk("chip_under_change", int'(change), 0);
    chk("chip_under_waiting", confirms, 2);
    amnt = 3'b011; press0();
    chk("chip_retry_change", int'(change), 1);
    chk("chip_retry_idle", confirms, -1);
    pick(3'b001); press0(); amnt = 3'b011; press0(); press0();
    chk("exact_change", int'(change), 0);
    chk("exact_idle", confirms, -1);
    pick(3'b001); b0 = 1'b0; tick(10); b0 = 1'b1; tick();
    chk("held_one_step", confirms, 1);
    amnt = 3'b111; press0(); press0();
    chk("held_then_pay", int'(change), 4);
    pick(3'b010); press0(); amnt = 3'b001; press0(); press0();
    b1 = 1'b0; tick(); b1 = 1'b1; tick();
    chk("cancel_change", int'(change), CANCEL ? 1 : 0);
    chk("cancel_state", confirms, CANCEL ? -1 : 2);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("mid_reset_change", int'(change), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      b0 = $urandom_range(0, 3) != 0;
      b1 = $urandom_range(0, 7) != 0;
      select = $urandom_range(0, 3) < 2 ? 3'($urandom_range(1, 2)) : 3'($urandom_range(0, 7));
      amnt = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; b0 = 1'b1; b1 = 1'b1; tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
